// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining an 8-bit registered-output FIFO: start, 8 data bits LSB first,
// optional parity (macro UART_TX_PARITY_EN), then STOP_BITS stop bits on a registered tx_o.
module uart_tx_fifo_drain #(
    parameter int CLKS_PER_BIT = 347,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en_i,
`ifdef UART_TX_PARITY_EN
    input  logic       parity_odd_i,
`endif
    input  logic [7:0] fifo_data_i,
    input  logic       fifo_empty_i,
    output logic       fifo_n_re_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       byte_done_o
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd6
`endif
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic [1:0]       settle, settle_n;
    logic             tx_n, busy_n, done_n, n_re_n;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par, par_n;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            settle      <= '0;
            tx_o        <= 1'b1;
            busy_o      <= 1'b0;
            byte_done_o <= 1'b0;
            fifo_n_re_o <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= idx_n;
            shift       <= shift_n;
            settle      <= settle_n;
            tx_o        <= tx_n;
            busy_o      <= busy_n;
            byte_done_o <= done_n;
            fifo_n_re_o <= n_re_n;
`ifdef UART_TX_PARITY_EN
            par         <= par_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = bit_idx;
        shift_n  = shift;
        settle_n = settle;
        done_n   = 1'b0;
        bit_end  = (cnt == CNT_LAST);
`ifdef UART_TX_PARITY_EN
        par_n    = par;
`endif
        case (state)
            IDLE: begin
                // Settle hides the FIFO empty flag lag so a last byte is never popped twice
                if (settle != 2'd0)
                    settle_n = settle - 2'd1;
                else if (tx_en_i && !fifo_empty_i)
                    state_n = POP;
            end
            POP: state_n = LOAD;
            LOAD: begin
                shift_n = fifo_data_i;
                cnt_n   = '0;
                idx_n   = '0;
                state_n = START;
`ifdef UART_TX_PARITY_EN
                par_n   = (^fifo_data_i) ^ parity_odd_i;
`endif
            end
            START: begin
                cnt_n = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                cnt_n = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) begin
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_n = bit_end ? '0 : cnt + 1'b1;
                if (bit_end) state_n = STOP;
            end
`endif
            STOP: begin
                cnt_n  = bit_end ? '0 : cnt + 1'b1;
                // Registered one cycle early so the pulse lands on the final stop cycle
                done_n = (bit_idx == STOP_LAST) && (cnt == CNT_PRE);
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        idx_n    = '0;
                        settle_n = 2'd2;
                        state_n  = IDLE;
                    end else begin
                        idx_n = bit_idx + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
        n_re_n = (state_n != POP);
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: FIFO model, UART line decoder and scoreboard of expected bytes.
module tb_uart_tx_fifo_drain;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SB = 2;
    localparam int PB = 1;
`else
    localparam int SB = 1;
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + 8 + PB + SB;
    localparam int FLEN  = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       n_re, tx, busy, done;

    int tests = 0, fails = 0;
    int pops = 0, dones = 0, frames = 0;
    int b2b_lo = -1, b2b_hi = -1;
    byte unsigned fifo_q[$];
    logic [8:0]   exp_q[$];
    logic e1 = 1'b1, prev_empty = 1'b1, prev_en = 1'b0, prev_nre = 1'b1;

    uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk),
        .rst(rst),
        .tx_en_i(tx_en),
`ifdef UART_TX_PARITY_EN
        .parity_odd_i(parity_odd),
`endif
        .fifo_data_i(fifo_data),
        .fifo_empty_i(fifo_empty),
        .fifo_n_re_o(n_re),
        .tx_o(tx),
        .busy_o(busy),
        .byte_done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // FIFO: registered data one clock after a sampled n_re low, empty flag two clocks behind
    always @(posedge clk) begin
        prev_empty <= fifo_empty;
        prev_en    <= tx_en;
        prev_nre   <= n_re;
        if (n_re === 1'b0) begin
            pops <= pops + 1;
            check("pop_fifo_has_data", fifo_q.size() != 0, 1);
            check("pop_flag_was_nonempty", prev_empty, 1'b0);
            check("pop_while_enabled", prev_en, 1'b1);
            check("pop_single_cycle", prev_nre, 1'b1);
            if (fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
        end
        e1         <= (fifo_q.size() == 0);
        fifo_empty <= e1;
    end

    always @(negedge clk) if (done === 1'b1) dones <= dones + 1;

    logic samp [FLEN];
    int   n = 0, gap = 0;
    bit   active = 1'b0;
    bit   busy_ok, done_ok;

    // Line decoder: collects a whole frame of samples, then judges it against the scoreboard
    initial begin : monitor
        logic [7:0] data;
        logic [8:0] e;
        bit shape_ok, start_ok, stop_ok;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                active = 1'b0;
                gap = 0;
                continue;
            end
            if (!active) begin
                if (tx === 1'b0) begin
                    if (frames >= b2b_lo && frames <= b2b_hi) check("b2b_gap", gap, 5);
                    active = 1'b1;
                    n = 0;
                    busy_ok = 1'b1;
                    done_ok = 1'b1;
                end else begin
                    gap++;
                    continue;
                end
            end
            samp[n] = tx;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== (n == FLEN - 1)) done_ok = 1'b0;
            n++;
            if (n == FLEN) begin
                shape_ok = 1'b1;
                for (int b = 0; b < NBITS; b++)
                    for (int k = 1; k < CPB; k++)
                        if (samp[b*CPB+k] !== samp[b*CPB]) shape_ok = 1'b0;
                start_ok = (samp[0] === 1'b0);
                stop_ok  = 1'b1;
                for (int s = 0; s < SB; s++)
                    if (samp[(9+PB+s)*CPB] !== 1'b1) stop_ok = 1'b0;
                for (int i = 0; i < 8; i++) data[i] = samp[(1+i)*CPB];
                check("frame_expected", exp_q.size() != 0, 1);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1xx;
                check("frame_data", data, e[7:0]);
                check("frame_bit_width", shape_ok, 1);
                check("frame_start_bit", start_ok, 1);
                check("frame_stop_bits", stop_ok, 1);
                check("busy_in_frame", busy_ok, 1);
                check("byte_done_last_cycle", done_ok, 1);
`ifdef UART_TX_PARITY_EN
                check("parity_bit", samp[9*CPB], (^e[7:0]) ^ e[8]);
`endif
                frames++;
                gap = 0;
                active = 1'b0;
            end
        end
    end

    task automatic push(input byte unsigned b);
        fifo_q.push_back(b);
        exp_q.push_back({parity_odd, b});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, k < budget, 1);
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_tx_low(input string name);
        int k = 0;
        while (tx !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, k < 200, 1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int p0, d0, hi;
        #1 rst = 1'b0;
        #2;
        check("reset_tx", tx, 1'b1);
        check("reset_n_re", n_re, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_byte_done", done, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tx_en = 1'b1;

        // single byte A5
        p0 = pops; d0 = dones;
        push(8'hA5);
        wait_drain("a5_timeout", 500);
        check("a5_pops", pops - p0, 1);
        check("a5_byte_done", dones - d0, 1);

        // three bytes back to back
        p0 = pops; d0 = dones;
        b2b_lo = frames + 1;
        b2b_hi = frames + 2;
        push(8'h00); push(8'hFF); push(8'h55);
        wait_drain("three_timeout", 1000);
        check("three_pops", pops - p0, 3);
        check("three_byte_done", dones - d0, 3);
        b2b_lo = -1; b2b_hi = -1;

        // single byte, then the line must stay idle
        p0 = pops;
        push(8'h81);
        wait_drain("single_timeout", 500);
        hi = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx === 1'b1 && busy === 1'b0) hi++;
        end
        check("single_idle_after", hi, 60);
        check("single_pops", pops - p0, 1);

        // tx_en dropped during START of 3C with two queued
        p0 = pops;
        push(8'h3C); push(8'h11); push(8'h22);
        wait_tx_low("en_start_seen");
        tx_en = 1'b0;
        hi = 0;
        while (exp_q.size() > 2 && hi < 500) begin
            @(negedge clk);
            hi++;
        end
        check("en_frame_finished", hi < 500, 1);
        repeat (80) @(negedge clk);
        check("en_hold_pops", pops - p0, 1);
        check("en_hold_fifo_left", fifo_q.size(), 2);
        check("en_hold_busy", busy, 1'b0);
        tx_en = 1'b1;
        wait_drain("en_resume_timeout", 1000);
        check("en_resume_pops", pops - p0, 3);

`ifdef UART_TX_PARITY_EN
        // byte 07, even parity, two stop bits
        parity_odd = 1'b0;
        p0 = pops;
        push(8'h07);
        wait_drain("par07_timeout", 500);
        check("par07_pops", pops - p0, 1);
`endif

        // reset in the middle of DATA
        p0 = pops;
        push(8'hC3);
        wait_tx_low("rst_start_seen");
        repeat (3 * CPB) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_async_tx", tx, 1'b1);
        check("rst_async_n_re", n_re, 1'b1);
        check("rst_async_busy", busy, 1'b0);
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        rst = 1'b1;
        hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx === 1'b1 && n_re === 1'b1 && busy === 1'b0) hi++;
        end
        check("rst_idle_after", hi, 30);
        check("rst_pops", pops - p0, 1);

        // randomized stream with enable toggling
        parity_odd = 1'($urandom);
        p0 = pops;
        for (int i = 0; i < 24; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 40)) begin
                @(negedge clk);
                tx_en = ($urandom_range(0, 3) != 0);
            end
        end
        tx_en = 1'b1;
        wait_drain("rand_timeout", 5000);
        check("rand_pops", pops - p0, 24);
        check("rand_fifo_empty", fifo_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
